// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Shares one CPU-style memory bus between two masters (m0 = CPU, m1 =
// debug/DMA). Each master gets a one-entry request buffer. Pending requests
// are granted round-robin and issued downstream one at a time. The response
// is routed back to the owning master. A watchdog completes a transaction
// that never sees memory_ready, returning zero data and pulsing bus_error.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mN_valid/instr/addr/
//     wdata/wstrb             master N request (wstrb == 0 means read)
//   mN_rdata, mN_ready        master N response data and completion pulse
//   memory_valid/instr/addr/
//     wdata/wstrb             downstream request (valid is a one-cycle pulse)
//   memory_rdata, memory_ready downstream response
//   bus_error                 one-cycle pulse alongside a timed-out completion
//
// Parameter:
//   TIMEOUT  cycles (counted from the issue cycle) to wait for memory_ready,
//            2..65535
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,

    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    // Per-master request buffers
    logic        pend0;
    logic        buf0_instr;
    logic [31:0] buf0_addr;
    logic [31:0] buf0_wdata;
    logic [3:0]  buf0_wstrb;
    logic        pend1;
    logic        buf1_instr;
    logic [31:0] buf1_addr;
    logic [31:0] buf1_wdata;
    logic [3:0]  buf1_wstrb;

    logic        owner;
    logic        last_grant;
    logic [15:0] timeout_cnt;
    logic        err_q;

    logic        grant;
    logic        grant_sel;
    logic        timeout_hit;
    logic        resp_capture;
    logic [31:0] resp_data;

    // Outputs that are pure functions of the FSM state
    assign memory_valid = (state == ISSUE);
    assign m0_ready     = (state == RESP) && !owner;
    assign m1_ready     = (state == RESP) &&  owner;
    assign bus_error    = (state == RESP) && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant decision and response capture. Ready beats timeout
    // when both land in the same WAIT cycle.
    always_comb begin
        state_next   = state;
        grant        = 1'b0;
        grant_sel    = 1'b0;
        timeout_hit  = 1'b0;
        resp_capture = 1'b0;
        resp_data    = 32'h0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant      = 1'b1;
                    grant_sel  = (pend0 && pend1) ? ~last_grant : pend1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (memory_ready) begin
                    resp_capture = 1'b1;
                    resp_data    = memory_rdata;
                    state_next   = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (memory_ready) begin
                    resp_capture = 1'b1;
                    resp_data    = memory_rdata;
                    state_next   = RESP;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit  = 1'b1;
                    resp_capture = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request buffers. A new valid is accepted when the buffer is empty, or
    // in the very cycle the previous request completes (the master is allowed
    // to chain its next request onto its ready pulse).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend0      <= 1'b0;
            buf0_instr <= 1'b0;
            buf0_addr  <= 32'h0;
            buf0_wdata <= 32'h0;
            buf0_wstrb <= 4'h0;
            pend1      <= 1'b0;
            buf1_instr <= 1'b0;
            buf1_addr  <= 32'h0;
            buf1_wdata <= 32'h0;
            buf1_wstrb <= 4'h0;
        end else begin
            if (m0_valid && (!pend0 || m0_ready)) begin
                pend0      <= 1'b1;
                buf0_instr <= m0_instr;
                buf0_addr  <= m0_addr;
                buf0_wdata <= m0_wdata;
                buf0_wstrb <= m0_wstrb;
            end else if (m0_ready) begin
                pend0 <= 1'b0;
            end

            if (m1_valid && (!pend1 || m1_ready)) begin
                pend1      <= 1'b1;
                buf1_instr <= m1_instr;
                buf1_addr  <= m1_addr;
                buf1_wdata <= m1_wdata;
                buf1_wstrb <= m1_wstrb;
            end else if (m1_ready) begin
                pend1 <= 1'b0;
            end
        end
    end

    // Downstream request registers, ownership, round-robin pointer and the
    // watchdog. The counter reads 0 in ISSUE and k in the k-th cycle after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memory_instr <= 1'b0;
            memory_addr  <= 32'h0;
            memory_wdata <= 32'h0;
            memory_wstrb <= 4'h0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            timeout_cnt  <= 16'h0;
        end else begin
            if (grant) begin
                memory_instr <= grant_sel ? buf1_instr : buf0_instr;
                memory_addr  <= grant_sel ? buf1_addr  : buf0_addr;
                memory_wdata <= grant_sel ? buf1_wdata : buf0_wdata;
                memory_wstrb <= grant_sel ? buf1_wstrb : buf0_wstrb;
                owner        <= grant_sel;
                last_grant   <= grant_sel;
                timeout_cnt  <= 16'h0;
            end else if (state == ISSUE || state == WAIT) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

    // Response data is latched per master so each side keeps its last value
    // between its own completions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
            err_q    <= 1'b0;
        end else if (resp_capture) begin
            err_q <= timeout_hit;
            if (owner) begin
                m1_rdata <= resp_data;
            end else begin
                m0_rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed testbench for memory_arbiter (TIMEOUT = 8). Cycle numbers in the
// comments count from the cycle in which a request is presented (cycle 0).
// Inputs are driven and outputs are checked 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_instr;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_rdata;
    logic        m0_ready;
    logic        m1_valid, m1_instr;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_rdata;
    logic        m1_ready;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        bus_error;

    int vectors_applied = 0;
    int miscompares     = 0;

    memory_arbiter #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_valid     (m0_valid),
        .m0_instr     (m0_instr),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_wstrb     (m0_wstrb),
        .m0_rdata     (m0_rdata),
        .m0_ready     (m0_ready),
        .m1_valid     (m1_valid),
        .m1_instr     (m1_instr),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_wstrb     (m1_wstrb),
        .m1_rdata     (m1_rdata),
        .m1_ready     (m1_ready),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready),
        .bus_error    (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL sim_watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int master, input logic valid,
                                 input logic instr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        if (master == 0) begin
            m0_valid = valid; m0_instr = instr; m0_addr = addr;
            m0_wdata = wdata; m0_wstrb = wstrb;
        end else begin
            m1_valid = valid; m1_instr = instr; m1_addr = addr;
            m1_wdata = wdata; m1_wstrb = wstrb;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single read through a slave that answers one cycle after memory_valid.
    task automatic run_read(input int master, input logic [31:0] addr,
                            input logic [31:0] data, input string tag);
        applyStimulus(master, 1'b1, 1'b0, addr, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(master, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2
        checkOutput({tag, "_issue"}, 32'(memory_valid), 32'd1);
        checkOutput({tag, "_addr"}, memory_addr, addr);
        tick;                                           // c3
        memory_ready = 1'b1; memory_rdata = data;
        tick;                                           // c4
        memory_ready = 1'b0; memory_rdata = 32'h0;
        checkOutput({tag, "_ready"}, 32'(master == 0 ? m0_ready : m1_ready), 32'd1);
        checkOutput({tag, "_rdata"}, master == 0 ? m0_rdata : m1_rdata, data);
        checkOutput({tag, "_other_ready"}, 32'(master == 0 ? m1_ready : m0_ready), 32'd0);
        tick;                                           // c5
    endtask

    initial begin
        logic        found;
        int          stray_ready;
        logic [31:0] exp_addr;

        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        memory_ready = 1'b0;
        memory_rdata = 32'h0;
        repeat (3) tick;

        // Reset state
        checkOutput("rst_memory_valid", 32'(memory_valid), 32'd0);
        checkOutput("rst_memory_addr", memory_addr, 32'h0);
        checkOutput("rst_m0_ready", 32'(m0_ready), 32'd0);
        checkOutput("rst_m1_ready", 32'(m1_ready), 32'd0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        rst = 1'b1;
        tick;

        // Simultaneous requests right after reset: m0 wins the tie
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2
        checkOutput("sim_first_issue", 32'(memory_valid), 32'd1);
        checkOutput("sim_first_addr", memory_addr, 32'h10);
        tick;                                           // c3
        memory_ready = 1'b1; memory_rdata = 32'h1010;
        tick;                                           // c4
        memory_ready = 1'b0;
        checkOutput("sim_m0_ready", 32'(m0_ready), 32'd1);
        checkOutput("sim_m0_rdata", m0_rdata, 32'h1010);
        checkOutput("sim_m1_ready_low", 32'(m1_ready), 32'd0);
        tick;                                           // c5
        tick;                                           // c6
        checkOutput("sim_second_issue", 32'(memory_valid), 32'd1);
        checkOutput("sim_second_addr", memory_addr, 32'h20);
        tick;                                           // c7
        memory_ready = 1'b1; memory_rdata = 32'h2020;
        tick;                                           // c8
        memory_ready = 1'b0;
        checkOutput("sim_m1_ready", 32'(m1_ready), 32'd1);
        checkOutput("sim_m1_rdata", m1_rdata, 32'h2020);
        checkOutput("sim_m0_ready_low", 32'(m0_ready), 32'd0);
        tick;

        // Continuous requests from both: grants alternate m0, m1, m0, m1.
        // memory_ready is held high throughout, so it is also stray in IDLE/RESP.
        memory_ready = 1'b1; memory_rdata = 32'h55;
        applyStimulus(0, 1'b1, 1'b0, 32'hA0, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'h0);
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick;
                if (memory_valid) found = 1'b1;
            end
            checkOutput($sformatf("rr_grant%0d_seen", g), 32'(found), 32'd1);
            exp_addr = (g % 2 == 0) ? 32'hA0 : 32'hB0;
            checkOutput($sformatf("rr_grant%0d_addr", g), memory_addr, exp_addr);
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (10) tick;
        memory_ready = 1'b0; memory_rdata = 32'h0;
        checkOutput("rr_m0_rdata", m0_rdata, 32'h55);
        tick;

        // Single instruction-fetch read from m0
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2
        checkOutput("rd_issue", 32'(memory_valid), 32'd1);
        checkOutput("rd_addr", memory_addr, 32'h100);
        checkOutput("rd_wstrb", 32'(memory_wstrb), 32'h0);
        checkOutput("rd_instr", 32'(memory_instr), 32'd1);
        tick;                                           // c3
        memory_ready = 1'b1; memory_rdata = 32'hDEADBEEF;
        checkOutput("rd_valid_pulse", 32'(memory_valid), 32'd0);
        tick;                                           // c4
        memory_ready = 1'b0; memory_rdata = 32'h0;
        checkOutput("rd_m0_ready", 32'(m0_ready), 32'd1);
        checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_m1_ready", 32'(m1_ready), 32'd0);
        tick;                                           // c5
        checkOutput("rd_m0_ready_pulse", 32'(m0_ready), 32'd0);
        checkOutput("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Write pass-through from m1
        applyStimulus(1, 1'b1, 1'b0, 32'h0010_0000, 32'h41, 4'h1);
        tick;                                           // c1
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2
        checkOutput("wr_issue", 32'(memory_valid), 32'd1);
        checkOutput("wr_addr", memory_addr, 32'h0010_0000);
        checkOutput("wr_wdata", memory_wdata, 32'h41);
        checkOutput("wr_wstrb", 32'(memory_wstrb), 32'h1);
        checkOutput("wr_instr", 32'(memory_instr), 32'd0);
        tick;                                           // c3
        memory_ready = 1'b1;
        tick;                                           // c4
        memory_ready = 1'b0;
        checkOutput("wr_m1_ready", 32'(m1_ready), 32'd1);
        checkOutput("wr_m0_ready", 32'(m0_ready), 32'd0);
        checkOutput("wr_m0_untouched", m0_rdata, 32'hDEADBEEF);
        tick;

        // Timeout on m0 with m1 queued behind it
        applyStimulus(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        tick;                                           // c2 (ISSUE)
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        memory_rdata = 32'hBAD0BAD0;
        checkOutput("to_issue_addr", memory_addr, 32'h200);
        repeat (7) tick;                                // c9
        checkOutput("to_not_yet_ready", 32'(m0_ready), 32'd0);
        checkOutput("to_not_yet_error", 32'(bus_error), 32'd0);
        tick;                                           // c10
        checkOutput("to_m0_ready", 32'(m0_ready), 32'd1);
        checkOutput("to_bus_error", 32'(bus_error), 32'd1);
        checkOutput("to_m0_rdata", m0_rdata, 32'h0);
        checkOutput("to_m1_ready", 32'(m1_ready), 32'd0);
        tick;                                           // c11
        checkOutput("to_error_pulse", 32'(bus_error), 32'd0);
        tick;                                           // c12
        checkOutput("to_next_issue", 32'(memory_valid), 32'd1);
        checkOutput("to_next_addr", memory_addr, 32'h300);
        tick;                                           // c13
        memory_ready = 1'b1; memory_rdata = 32'h3333;
        tick;                                           // c14
        memory_ready = 1'b0; memory_rdata = 32'h0;
        checkOutput("to_m1_ready", 32'(m1_ready), 32'd1);
        checkOutput("to_m1_rdata", m1_rdata, 32'h3333);
        checkOutput("to_m1_no_error", 32'(bus_error), 32'd0);
        tick;

        // Ready arrives in the timeout cycle: ready wins
        applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2 (ISSUE)
        repeat (7) tick;                                // c9
        memory_ready = 1'b1; memory_rdata = 32'hCAFE0001;
        tick;                                           // c10
        memory_ready = 1'b0; memory_rdata = 32'h0;
        checkOutput("race_m0_ready", 32'(m0_ready), 32'd1);
        checkOutput("race_m0_rdata", m0_rdata, 32'hCAFE0001);
        checkOutput("race_no_error", 32'(bus_error), 32'd0);
        tick;

        // Reset while waiting for the slave
        applyStimulus(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        tick;                                           // c1
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;                                           // c2 (ISSUE)
        tick;                                           // c3 (WAIT)
        tick;                                           // c4 (WAIT)
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(memory_valid), 32'd0);
        checkOutput("mid_rst_addr", memory_addr, 32'h0);
        checkOutput("mid_rst_m0_ready", 32'(m0_ready), 32'd0);
        checkOutput("mid_rst_m0_rdata", m0_rdata, 32'h0);
        tick;
        tick;
        rst = 1'b1;
        stray_ready = 0;
        memory_ready = 1'b1; memory_rdata = 32'h77;
        for (int c = 0; c < 10; c++) begin
            tick;
            memory_ready = 1'b0;
            if (m0_ready || m1_ready) stray_ready++;
        end
        checkOutput("mid_rst_no_ready", 32'(stray_ready), 32'd0);
        run_read(0, 32'h600, 32'h12345678, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
